mtr_drv_pwm: RTL and testbench

//  Motor drive stage fed by the wheel-speed math: converts signed lft_spd/rght_spd into

---
 rtl/mtr_drv_pwm.sv | 137 +++++++++++++
 tb/tb_mtr_drv_pwm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv_pwm.sv
// Dual H-bridge PWM stage: signed wheel speeds -> complementary gate pairs with dead time.
// Define OVR_I_SHTDWN_EN to enable overcurrent sampling and the latched FAULT shutdown.
module mtr_drv_pwm #(
  parameter int unsigned NONOVERLAP = 32,
  parameter int unsigned BLANK      = 64,
  parameter int unsigned OVR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  input  logic        clr_fault,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        prd_strt,
  output logic        ovr_fault
);

  localparam logic [11:0] NOV = 12'(NONOVERLAP);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt;
  logic [10:0] duty_lft_q, duty_rght_q;
  logic        prd_end, run, limit_hit, clr_go;
  logic [1:0]  gate_lft, gate_rght;
  logic        unused_lsb;

  // Speed LSB is dropped by the duty mapping.
  assign unused_lsb = lft_spd[0] ^ rght_spd[0];
  assign prd_end    = (cnt == 11'h7FF);
  assign run        = (state_q == ST_RUN);

  // Returns {high_side, low_side}; 12-bit compare so duty+dead time never wraps.
  function automatic logic [1:0] gate_calc(input logic [10:0] c, input logic [10:0] d,
                                           input logic en);
    logic [11:0] c12, d12;
    c12 = {1'b0, c};
    d12 = {1'b0, d};
    gate_calc[1] = en && (c12 >= NOV) && (c < d);
    gate_calc[0] = en && (c12 >= d12 + NOV);
  endfunction

  assign gate_lft  = gate_calc(cnt, duty_lft_q, run);
  assign gate_rght = gate_calc(cnt, duty_rght_q, run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      duty_lft_q  <= 11'h400;
      duty_rght_q <= 11'h400;
      PWM1_lft    <= 1'b0;
      PWM2_lft    <= 1'b0;
      PWM1_rght   <= 1'b0;
      PWM2_rght   <= 1'b0;
      prd_strt    <= 1'b0;
    end else begin
      cnt <= cnt + 11'd1;
      if (prd_end) begin
        duty_lft_q  <= {~lft_spd[11], lft_spd[10:1]};
        duty_rght_q <= {~rght_spd[11], rght_spd[10:1]};
      end
      {PWM1_lft, PWM2_lft}   <= gate_lft;
      {PWM1_rght, PWM2_rght} <= gate_rght;
      prd_strt               <= (cnt == 11'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (limit_hit) state_d = ST_FAULT;
      ST_FAULT: if (clr_go)    state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

`ifdef OVR_I_SHTDWN_EN
  localparam logic [11:0] SAMPLE_START = 12'(NONOVERLAP + BLANK);
  localparam logic [3:0]  LIMIT        = 4'(OVR_LIMIT);

  logic       flag_lft, flag_rght, hit_lft, hit_rght, ovr_prd, clr_pend;
  logic [3:0] ovr_cnt;

  // Comparator output is only trusted once the turn-on transient has settled.
  assign hit_lft   = OVR_I_lft  && PWM1_lft  && ({1'b0, cnt} >= SAMPLE_START);
  assign hit_rght  = OVR_I_rght && PWM1_rght && ({1'b0, cnt} >= SAMPLE_START);
  assign ovr_prd   = flag_lft | flag_rght | hit_lft | hit_rght;
  assign limit_hit = run && (ovr_cnt >= LIMIT);
  assign clr_go    = (clr_pend || clr_fault) && prd_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_lft  <= 1'b0;
      flag_rght <= 1'b0;
      ovr_cnt   <= '0;
      clr_pend  <= 1'b0;
      ovr_fault <= 1'b0;
    end else begin
      if (prd_end) begin
        flag_lft  <= 1'b0;
        flag_rght <= 1'b0;
      end else begin
        flag_lft  <= flag_lft  | hit_lft;
        flag_rght <= flag_rght | hit_rght;
      end
      if (!run)         ovr_cnt <= '0;
      else if (prd_end) ovr_cnt <= !ovr_prd ? 4'd0 :
                                   (ovr_cnt == 4'hF) ? ovr_cnt : ovr_cnt + 4'd1;
      // A clear request only counts while already faulted; one that races the limit is lost.
      clr_pend  <= (state_q == ST_FAULT) && (state_d == ST_FAULT) && (clr_pend || clr_fault);
      ovr_fault <= (state_q == ST_FAULT);
    end
  end
`else
  logic unused_ovr;

  assign unused_ovr = ^{OVR_I_lft, OVR_I_rght, clr_fault, BLANK[0], OVR_LIMIT[0]};
  assign limit_hit  = 1'b0;
  assign clr_go     = 1'b0;
  assign ovr_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: per-period gate profiles checked against a duty model through a queue.
module tb_mtr_drv_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_spd = '0;
  logic [11:0] rght_spd = '0;
  logic        ovr_i_lft = 1'b0;
  logic        ovr_i_rght = 1'b0;
  logic        clr_fault = 1'b0;
  logic        pwm1_lft, pwm2_lft, pwm1_rght, pwm2_rght, prd_strt, ovr_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [95:0] exp_q[$];
  int          hi_n[4];
  int          hi_f[4];
  int          ovl, pbad, g_m;
  logic        ovr_seen = 1'b0;
  logic [95:0] exp_v, meas;
  logic [11:0] cur_l, cur_r;

  localparam logic [95:0] ALL_OFF = {4{24'h000FFF}};

  typedef struct {
    logic [11:0] lft;
    logic [11:0] rght;
    logic [95:0] exp_prd;
  } vec_t;
  vec_t vecs[5];

  mtr_drv_pwm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lft_spd    (lft_spd),
    .rght_spd   (rght_spd),
    .OVR_I_lft  (ovr_i_lft),
    .OVR_I_rght (ovr_i_rght),
    .clr_fault  (clr_fault),
    .PWM1_lft   (pwm1_lft),
    .PWM2_lft   (pwm2_lft),
    .PWM1_rght  (pwm1_rght),
    .PWM2_rght  (pwm2_rght),
    .prd_strt   (prd_strt),
    .ovr_fault  (ovr_fault)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // cyc counts rising edges since reset release; gates seen after edge n reflect cnt n-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- model ----------------
  // Per gate: {12-bit high count, 12-bit first high cnt or FFF}; order p1, p2.
  function automatic logic [47:0] side_model(input logic [11:0] spd);
    int d, p1n, p1f, p2s, p2n, p2f;
    d = (int'($signed(spd)) + 2048) / 2;
    if (d > 32) begin p1n = d - 32; p1f = 32; end
    else        begin p1n = 0;      p1f = 'hFFF; end
    p2s = d + 32;
    if (p2s <= 2047) begin p2n = 2048 - p2s; p2f = p2s; end
    else             begin p2n = 0;          p2f = 'hFFF; end
    return {12'(p1n), 12'(p1f), 12'(p2n), 12'(p2f)};
  endfunction

  function automatic logic [95:0] model(input logic [11:0] l, input logic [11:0] r);
    return {side_model(l), side_model(r)};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      g_m = (cyc - 1) % 2048;
      if (g_m == 0) begin
        for (int i = 0; i < 4; i++) begin
          hi_n[i] = 0;
          hi_f[i] = 'hFFF;
        end
        ovl  = 0;
        pbad = 0;
      end
      if (pwm1_lft)  begin hi_n[0]++; if (hi_f[0] == 'hFFF) hi_f[0] = g_m; end
      if (pwm2_lft)  begin hi_n[1]++; if (hi_f[1] == 'hFFF) hi_f[1] = g_m; end
      if (pwm1_rght) begin hi_n[2]++; if (hi_f[2] == 'hFFF) hi_f[2] = g_m; end
      if (pwm2_rght) begin hi_n[3]++; if (hi_f[3] == 'hFFF) hi_f[3] = g_m; end
      if ((pwm1_lft && pwm2_lft) || (pwm1_rght && pwm2_rght)) ovl++;
      if (prd_strt != (g_m == 0)) pbad++;
      if (ovr_fault) ovr_seen = 1'b1;
      if (g_m == 2047 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        meas  = {12'(hi_n[0]), 12'(hi_f[0]), 12'(hi_n[1]), 12'(hi_f[1]),
                 12'(hi_n[2]), 12'(hi_f[2]), 12'(hi_n[3]), 12'(hi_f[3])};
        check("period", meas, exp_v);
        check("overlap", 96'(ovl), 96'd0);
        check("prd_strt", 96'(pbad), 96'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_g(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rst_n && cyc > 0 && ((cyc - 1) % 2048) == target)) begin
      n++;
      if (n > 4200) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_g: cnt %0d not reached, cyc=%0d", target, cyc);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      n++;
      if (n > 3 * 2048 + 16) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_empty: %0d periods pending, required 0", exp_q.size());
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fault(output int g_at);
    int n;
    n = 0;
    g_at = -1;
    while (!ovr_fault) begin
      n++;
      if (n > 6 * 2048) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_fault: ovr_fault still 0, required 1");
        return;
      end
      @(negedge clk);
    end
    g_at = (cyc - 1) % 2048;
  endtask

  task automatic reset_mid();
    wait_g(900);
    rst_n = 1'b0;
    #1;
    check("rst_async", 96'({pwm1_lft, pwm2_lft, pwm1_rght, pwm2_rght, prd_strt, ovr_fault}),
          96'd0);
    lft_spd    = 12'h7FF;
    rght_spd   = 12'h800;
    ovr_i_lft  = 1'b0;
    ovr_i_rght = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // First period after reset runs at the reset duty whatever the inputs say.
    exp_q.push_back(model(12'h000, 12'h000));
    exp_q.push_back(model(12'h7FF, 12'h800));
    cur_l = 12'h7FF;
    cur_r = 12'h800;
    wait_empty();
  endtask

  // ---------------- test ----------------
  initial begin
    int g_at;
    vecs[0] = '{12'h000, 12'h200, model(12'h000, 12'h200)};
    vecs[1] = '{12'h7FF, 12'h800, model(12'h7FF, 12'h800)};
    vecs[2] = '{12'h840, 12'h842, model(12'h840, 12'h842)};
    vecs[3] = '{12'h7BE, 12'h7C0, model(12'h7BE, 12'h7C0)};
    vecs[4] = '{12'hFFF, 12'h001, model(12'hFFF, 12'h001)};

    repeat (3) @(negedge clk);
    check("reset_outs", 96'({pwm1_lft, pwm2_lft, pwm1_rght, pwm2_rght, prd_strt, ovr_fault}),
          96'd0);
    rst_n = 1'b1;
    cur_l = 12'h000;
    cur_r = 12'h000;

    // Inputs change mid-period: current period keeps old duty, next one uses the new.
    for (int i = 0; i < 5; i++) begin
      wait_g(500);
      exp_q.push_back(model(cur_l, cur_r));
      lft_spd  = vecs[i].lft;
      rght_spd = vecs[i].rght;
      exp_q.push_back(vecs[i].exp_prd);
      cur_l = vecs[i].lft;
      cur_r = vecs[i].rght;
      wait_empty();
    end

`ifdef OVR_I_SHTDWN_EN
    wait_g(500);
    ovr_i_lft = 1'b1;
    wait_fault(g_at);
    check("fault_time", 96'(g_at), 96'd1);
    exp_q.push_back(ALL_OFF);
    wait_g(40);
    check("fault_gates", 96'({pwm1_lft, pwm2_lft, pwm1_rght, pwm2_rght}), 96'd0);
    wait_empty();
    wait_g(100);
    check("fault_held", 96'(ovr_fault), 96'd1);
    reset_mid();

    wait_g(500);
    ovr_i_lft = 1'b1;
    wait_fault(g_at);
    ovr_i_lft = 1'b0;
    wait_g(700);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    wait_g(2047);
    check("clr_pending", 96'(ovr_fault), 96'd1);
    wait_g(10);
    check("clr_release", 96'(ovr_fault), 96'd0);
    exp_q.push_back(model(cur_l, cur_r));
    wait_empty();

    ovr_seen = 1'b0;
    for (int n = 0; n < 4 * 2048; n++) begin
      @(negedge clk);
      ovr_i_lft = (((cyc - 1) % 2048 + 1) % 2048) < 96;
    end
    ovr_i_lft = 1'b0;
    check("no_fault_blank", 96'(ovr_seen), 96'd0);

    ovr_seen = 1'b0;
    wait_g(2047);
    for (int p = 0; p < 5; p++) begin
      ovr_i_lft = (p % 2 == 0);
      repeat (2048) @(negedge clk);
    end
    ovr_i_lft = 1'b0;
    check("no_fault_alt", 96'(ovr_seen), 96'd0);
`else
    ovr_seen = 1'b0;
    wait_g(500);
    ovr_i_lft  = 1'b1;
    ovr_i_rght = 1'b1;
    exp_q.push_back(model(cur_l, cur_r));
    exp_q.push_back(model(cur_l, cur_r));
    wait_g(600);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    wait_empty();
    ovr_i_lft  = 1'b0;
    ovr_i_rght = 1'b0;
    check("ovr_ignored", 96'(ovr_seen), 96'd0);
    reset_mid();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
